// File: rtl/tx_uart_fifo.sv
// tx_uart_fifo: UART transmitter with run-time frame format and a small TX FIFO.
module tx_uart_fifo #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int N_DATA     = 8,
  parameter int NB_STATE   = 5
) (
  input  logic                clock,
  input  logic                reset_i,
  input  logic                s_tick,
  input  logic                wr_en,
  input  logic [N_DATA-1:0]   din,
  input  logic [1:0]          data_bits,
  input  logic [1:0]          parity_mode,
  input  logic                stop_bits,
  output logic                tx,
  output logic                tx_done_tick,
  output logic                busy,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic [NB_STATE-1:0] state
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;
  logic [N_DATA-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_count;
  logic              r_ovf;
  state_t            r_state;
  logic              r_tx, r_done, r_pend, r_sbits;
  logic [1:0]        r_dbits, r_pmode;
  logic [TW-1:0]     r_tick;
  logic [2:0]        r_bit;
  logic [N_DATA-1:0] r_shift;
  logic              w_full, w_empty, w_push, w_pop, w_tick_end, w_stop_done, w_par;
  logic [2:0]        w_len_m1, w_bit_nx;
  assign w_full      = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_empty     = r_count == '0;
  assign w_push      = wr_en && !w_full;
  assign w_tick_end  = s_tick && r_tick == TW'(OVERSAMPLE - 1);
  assign w_len_m1    = {1'b0, r_dbits} + 3'd4;
  assign w_bit_nx    = r_bit + 3'd1;
  assign w_stop_done = r_state == STOP && w_tick_end && r_bit == {2'b0, r_sbits};
  assign w_par       = ^(r_shift & (8'hff >> (2'd3 - r_dbits))) ^ r_pmode[1];
  // Popping on the final stop tick lets the next frame start after a single idle cycle
  assign w_pop       = !w_empty && ((r_state == IDLE && !r_pend) || w_stop_done);
  assign tx           = r_tx;
  assign tx_done_tick = r_done;
  assign busy         = r_state != IDLE;
  assign full         = w_full;
  assign empty        = w_empty;
  assign overflow     = r_ovf;
  assign state        = r_state;
  always_ff @(posedge clock)
    if (w_push) r_mem[r_wptr] <= din;
  always_ff @(posedge clock or posedge reset_i)
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (wr_en && w_full) r_ovf <= 1'b1;
    end
  always_ff @(posedge clock or posedge reset_i)
    if (reset_i) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_pend  <= 1'b0;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_dbits <= '0;
      r_pmode <= '0;
      r_sbits <= 1'b0;
    end else begin
      r_done <= w_stop_done;
      if (r_state != IDLE && s_tick) r_tick <= w_tick_end ? '0 : r_tick + 1'b1;
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_tick <= '0;
          r_bit  <= '0;
          if (r_pend) begin
            r_state <= START;
            r_tx    <= 1'b0;
            r_pend  <= 1'b0;
          end
        end
        START:
          if (w_tick_end) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
            r_bit   <= '0;
          end
        DATA:
          if (w_tick_end) begin
            if (r_bit == w_len_m1) begin
              r_state <= ^r_pmode ? PARITY : STOP;
              r_tx    <= ^r_pmode ? w_par : 1'b1;
              r_bit   <= '0;
            end else begin
              r_bit <= w_bit_nx;
              r_tx  <= r_shift[w_bit_nx];
            end
          end
        PARITY:
          if (w_tick_end) begin
            r_state <= STOP;
            r_tx    <= 1'b1;
            r_bit   <= '0;
          end
        STOP:
          if (w_tick_end) begin
            r_state <= w_stop_done ? IDLE : STOP;
            r_bit   <= w_stop_done ? 3'd0 : w_bit_nx;
            r_tx    <= 1'b1;
          end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
      if (w_pop) begin
        r_shift <= r_mem[r_rptr];
        r_dbits <= data_bits;
        r_pmode <= parity_mode;
        r_sbits <= stop_bits;
        r_pend  <= 1'b1;
      end
    end
endmodule
